// File: rtl/aclock_pkg.sv
// aclock_pkg: shared ring-state enum, BCD time struct and BCD helper functions for the alarm clock
package aclock_pkg;

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} ring_state_t;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
        logic [3:0] s1;
        logic [3:0] s0;
    } bcd_time_t;

    function automatic logic bcd_hm_valid(input logic [1:0] h1, input logic [3:0] h0,
                                          input logic [3:0] m1, input logic [3:0] m0);
        return h0 <= 4'd9 && m1 <= 4'd5 && m0 <= 4'd9 && (h1 < 2'd2 || (h1 == 2'd2 && h0 <= 4'd3));
    endfunction

    // Returns {tens[1:0], units[3:0]} of the 12-hour representation of a 24-hour BCD hour
    function automatic logic [5:0] to12h(input logic [1:0] h1, input logic [3:0] h0);
        logic [4:0] h;
        h = 5'd10 * {3'b0, h1} + {1'b0, h0};
        h = h == 5'd0 ? 5'd12 : h > 5'd12 ? h - 5'd12 : h;
        return h >= 5'd10 ? {2'd1, 4'(h - 5'd10)} : {2'd0, h[3:0]};
    endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// bcd_time_counter: prescaled HH:MM:SS BCD timekeeper with validated time load and a registered tick
module bcd_time_counter
    import aclock_pkg::*;
#(
    parameter int CLK_FREQ = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_ld,
    input  logic [1:0] i_h1,
    input  logic [3:0] i_h0,
    input  logic [3:0] i_m1,
    input  logic [3:0] i_m0,
    output bcd_time_t  o_time,
    output logic       o_tick
);

    localparam int PW = CLK_FREQ > 1 ? $clog2(CLK_FREQ) : 1;

    logic [PW-1:0] r_pre;
    logic          r_tick;
    bcd_time_t     r_t;
    bcd_time_t     w_next;
    logic          w_wrap;
    logic          w_ld_ok;
    logic          w_s_c;
    logic          w_m_c;
    logic          w_h_c;

    assign w_wrap  = r_pre == PW'(CLK_FREQ - 1);
    assign w_ld_ok = bcd_hm_valid(i_h1, i_h0, i_m1, i_m0);
    assign o_time  = r_t;
    assign o_tick  = r_tick;

    always_comb begin
        w_s_c     = r_t.s1 == 4'd5 && r_t.s0 == 4'd9;
        w_m_c     = w_s_c && r_t.m1 == 4'd5 && r_t.m0 == 4'd9;
        w_h_c     = w_m_c && r_t.h1 == 2'd2 && r_t.h0 == 4'd3;
        w_next    = r_t;
        w_next.s0 = r_t.s0 == 4'd9 ? 4'd0 : r_t.s0 + 4'd1;
        w_next.s1 = r_t.s0 != 4'd9 ? r_t.s1 : w_s_c ? 4'd0 : r_t.s1 + 4'd1;
        w_next.m0 = !w_s_c ? r_t.m0 : r_t.m0 == 4'd9 ? 4'd0 : r_t.m0 + 4'd1;
        w_next.m1 = !w_s_c || r_t.m0 != 4'd9 ? r_t.m1 : w_m_c ? 4'd0 : r_t.m1 + 4'd1;
        w_next.h0 = !w_m_c ? r_t.h0 : w_h_c || r_t.h0 == 4'd9 ? 4'd0 : r_t.h0 + 4'd1;
        w_next.h1 = !w_m_c ? r_t.h1 : w_h_c ? 2'd0 : r_t.h0 == 4'd9 ? r_t.h1 + 2'd1 : r_t.h1;
    end

    // A rejected load freezes time and prescaler for that cycle instead of counting through it
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pre  <= '0;
            r_tick <= 1'b0;
            r_t    <= '0;
        end else if (i_ld) begin
            r_tick <= 1'b0;
            if (w_ld_ok) begin
                r_pre <= '0;
                r_t   <= {i_h1, i_h0, i_m1, i_m0, 8'h00};
            end
        end else begin
            r_tick <= w_wrap;
            r_pre  <= w_wrap ? '0 : r_pre + PW'(1);
            if (w_wrap) r_t <= w_next;
        end
    end

endmodule

// File: rtl/aclock_multi.sv
// aclock_multi: 24-hour BCD clock with NUM_ALARMS armed alarms, snooze, ring timeout and 12/24-hour display
module aclock_multi
    import aclock_pkg::*;
#(
    parameter int  CLK_FREQ   = 10,
    parameter int  NUM_ALARMS = 4,
    parameter int  SNOOZE_MIN = 5,
    parameter int  RING_MAX_S = 60,
    localparam int AW         = NUM_ALARMS > 1 ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            H_in1,
    input  logic [3:0]            H_in0,
    input  logic [3:0]            M_in1,
    input  logic [3:0]            M_in0,
    input  logic                  LD_time,
    input  logic                  LD_alarm,
    input  logic [AW-1:0]         AL_SEL,
    input  logic [NUM_ALARMS-1:0] AL_EN,
    input  logic                  STOP_al,
    input  logic                  SNOOZE,
    input  logic                  MODE_12H,
    output logic                  Alarm,
    output logic [AW-1:0]         Alarm_id,
    output logic [1:0]            H_out1,
    output logic [3:0]            H_out0,
    output logic [3:0]            M_out1,
    output logic [3:0]            M_out0,
    output logic [3:0]            S_out1,
    output logic [3:0]            S_out0,
    output logic                  PM,
    output logic                  tick
);

    localparam int SNZ_S = SNOOZE_MIN * 60;
    localparam int CW    = $clog2((SNZ_S > RING_MAX_S ? SNZ_S : RING_MAX_S) + 1);

    bcd_time_t     w_t;
    logic          r_tick_d;
    logic          w_ld_ok;
    logic          w_al_ok;
    logic          w_sec0;
    logic          w_hit;
    logic [AW-1:0] w_hit_id;
    logic [AW-1:0] r_id;
    logic [13:0]   r_al [NUM_ALARMS];
    ring_state_t   r_state;
    ring_state_t   w_state_nx;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nx;
    logic          w_disarm;
    logic [5:0]    w_h12;

    bcd_time_counter #(.CLK_FREQ(CLK_FREQ)) u_time (
        .clk    (clk),
        .reset  (reset),
        .i_ld   (LD_time),
        .i_h1   (H_in1),
        .i_h0   (H_in0),
        .i_m1   (M_in1),
        .i_m0   (M_in0),
        .o_time (w_t),
        .o_tick (tick)
    );

    assign w_ld_ok  = LD_time && bcd_hm_valid(H_in1, H_in0, M_in1, M_in0);
    assign w_al_ok  = LD_alarm && bcd_hm_valid(H_in1, H_in0, M_in1, M_in0)
                      && {1'b0, AL_SEL} < (AW + 1)'(NUM_ALARMS);
    assign w_sec0   = r_tick_d && w_t.s1 == 4'd0 && w_t.s0 == 4'd0;
    assign w_disarm = !AL_EN[r_id];

    // Descending scan so the lowest matching index is the one left standing
    always_comb begin
        w_hit    = 1'b0;
        w_hit_id = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--)
            if (AL_EN[i] && r_al[i] == {w_t.h1, w_t.h0, w_t.m1, w_t.m0}) begin
                w_hit    = w_sec0;
                w_hit_id = AW'(i);
            end
    end

    // A valid time load clears tick_d so a load onto HH:MM:00 can never look like a minute boundary
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tick_d <= 1'b0;
            for (int i = 0; i < NUM_ALARMS; i++) r_al[i] <= '0;
        end else begin
            r_tick_d <= tick && !w_ld_ok;
            if (w_al_ok) r_al[AL_SEL] <= {H_in1, H_in0, M_in1, M_in0};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_id    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            if (r_state == IDLE && w_hit) r_id <= w_hit_id;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    w_state_nx = w_hit ? RINGING : IDLE;
            RINGING: w_state_nx = w_disarm || STOP_al ? IDLE : SNOOZE ? SNOOZED : r_cnt == '0 ? IDLE : RINGING;
            SNOOZED: w_state_nx = w_disarm || STOP_al ? IDLE : r_cnt == '0 ? RINGING : SNOOZED;
            default: w_state_nx = IDLE;
        endcase
        w_cnt_nx = w_state_nx == SNOOZED && r_state != SNOOZED ? CW'(SNZ_S)
                 : w_state_nx == RINGING && r_state != RINGING ? CW'(RING_MAX_S)
                 : tick && r_cnt != '0 ? r_cnt - CW'(1) : r_cnt;
    end

    always_comb begin
        Alarm    = r_state == RINGING;
        Alarm_id = r_id;
        w_h12    = to12h(w_t.h1, w_t.h0);
        H_out1   = MODE_12H ? w_h12[5:4] : w_t.h1;
        H_out0   = MODE_12H ? w_h12[3:0] : w_t.h0;
        M_out1   = w_t.m1;
        M_out0   = w_t.m0;
        S_out1   = w_t.s1;
        S_out0   = w_t.s0;
        PM       = w_t.h1 == 2'd2 || (w_t.h1 == 2'd1 && w_t.h0 >= 4'd2);
    end

endmodule

// File: tb/tb_aclock_multi.sv
// tb_aclock_multi: directed and randomized checks against a seconds-of-day reference model of the alarm clock
module tb_aclock_multi;

    localparam int CF = 2;
    localparam int NA = 4;
    localparam int SM = 1;
    localparam int RM = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0;
    logic       LD_time, LD_alarm;
    logic [1:0] AL_SEL;
    logic [3:0] AL_EN;
    logic       STOP_al, SNOOZE, MODE_12H;
    logic       Alarm;
    logic [1:0] Alarm_id;
    logic [1:0] H_out1;
    logic [3:0] H_out0, M_out1, M_out0, S_out1, S_out0;
    logic       PM, tick;

    int n_tests = 0;
    int n_fail = 0;

    int   m_sec, m_pre, m_st, m_cnt, m_id;
    int   m_al [NA];
    logic m_tick, m_tickd;

    always #5 clk = ~clk;

    aclock_multi #(.CLK_FREQ(CF), .NUM_ALARMS(NA), .SNOOZE_MIN(SM), .RING_MAX_S(RM)) dut (
        .clk(clk), .reset(reset), .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm), .AL_SEL(AL_SEL), .AL_EN(AL_EN),
        .STOP_al(STOP_al), .SNOOZE(SNOOZE), .MODE_12H(MODE_12H),
        .Alarm(Alarm), .Alarm_id(Alarm_id), .H_out1(H_out1), .H_out0(H_out0),
        .M_out1(M_out1), .M_out0(M_out0), .S_out1(S_out1), .S_out0(S_out0), .PM(PM), .tick(tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dtime();
        return {10'b0, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};
    endfunction

    function automatic logic [31:0] etime(input int hd, input int mi, input int s);
        return {10'b0, 2'(hd / 10), 4'(hd % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    // Reference: time is a seconds-of-day integer, alarms are minutes-of-day; state 0 idle, 1 ringing, 2 snoozed
    task automatic model_edge();
        int hr, mn, hit, nst;
        bit ok;
        hr  = H_in1 * 10 + H_in0;
        mn  = M_in1 * 10 + M_in0;
        ok  = H_in0 <= 9 && M_in0 <= 9 && M_in1 <= 9 && hr <= 23 && mn <= 59;
        hit = -1;
        if (!reset) begin
            m_sec = 0; m_pre = 0; m_tick = 0; m_tickd = 0;
            m_st = 0; m_cnt = 0; m_id = 0;
            for (int i = 0; i < NA; i++) m_al[i] = 0;
        end else begin
            if (m_tickd && m_sec % 60 == 0)
                for (int i = NA - 1; i >= 0; i--) if (AL_EN[i] && m_al[i] == m_sec / 60) hit = i;
            nst = m_st;
            if (m_st == 0 && hit >= 0) begin nst = 1; m_id = hit; end
            else if (m_st != 0 && (!AL_EN[m_id] || STOP_al)) nst = 0;
            else if (m_st == 1) nst = SNOOZE ? 2 : m_cnt == 0 ? 0 : 1;
            else if (m_st == 2 && m_cnt == 0) nst = 1;
            if (nst != m_st && nst == 1) m_cnt = RM;
            else if (nst != m_st && nst == 2) m_cnt = SM * 60;
            else if (m_tick && m_cnt > 0) m_cnt--;
            m_st = nst;
            if (LD_alarm && ok) m_al[AL_SEL] = hr * 60 + mn;
            m_tickd = m_tick && !(LD_time && ok);
            if (LD_time) begin
                m_tick = 0;
                if (ok) begin m_sec = hr * 3600 + mn * 60; m_pre = 0; end
            end else begin
                m_tick = m_pre == CF - 1;
                m_pre  = (m_pre + 1) % CF;
                if (m_tick) m_sec = (m_sec + 1) % 86400;
            end
        end
    endtask

    task automatic check_all();
        int h, hd;
        h  = m_sec / 3600;
        hd = !MODE_12H ? h : h == 0 ? 12 : h > 12 ? h - 12 : h;
        chk("alarm", Alarm, m_st == 1);
        chk("alarm_id", Alarm_id, m_id);
        chk("time", dtime(), etime(hd, m_sec / 60 % 60, m_sec % 60));
        chk("pm", PM, h >= 12);
        chk("tick", tick, m_tick);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic set_hm(input int h, input int m);
        H_in1 = 2'(h / 10); H_in0 = 4'(h % 10); M_in1 = 4'(m / 10); M_in0 = 4'(m % 10);
    endtask

    task automatic load_time(input int h, input int m);
        set_hm(h, m); LD_time = 1'b1; step(); LD_time = 1'b0;
    endtask

    task automatic load_alarm(input int k, input int h, input int m);
        set_hm(h, m); AL_SEL = 2'(k); LD_alarm = 1'b1; step(); LD_alarm = 1'b0;
    endtask

    task automatic wait_alarm(input logic lvl, input int max, output int n);
        n = 0;
        while (Alarm !== lvl && n < max) begin step(); n++; end
        chk("wait_alarm", Alarm, lvl);
    endtask

    task automatic count_high(input int cyc, output int n);
        n = 0;
        repeat (cyc) begin step(); if (Alarm === 1'b1) n++; end
    endtask

    initial begin
        int n, k, hh, mm;
        {H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, AL_SEL, AL_EN, STOP_al, SNOOZE, MODE_12H} = '0;
        step(); step();
        chk("rst_time", dtime(), 32'h000000);
        MODE_12H = 1'b1; #1;
        chk("rst_12h", dtime(), 32'h120000);
        MODE_12H = 1'b0;
        reset = 1'b1;

        load_time(23, 59);
        chk("ld_2359", dtime(), 32'h235900);
        chk("pm_2359", PM, 1);
        repeat (120) step();
        chk("wrap_0000", dtime(), 32'h000000);
        chk("pm_wrap", PM, 0);
        repeat (2) step();
        chk("wrap_0001", dtime(), 32'h000001);
        H_in1 = 2'd2; H_in0 = 4'd4; M_in1 = 4'd0; M_in0 = 4'd0; LD_time = 1'b1; step(); LD_time = 1'b0;
        chk("ld_invalid", dtime(), 32'h000001);

        repeat (16) begin
            H_in1 = 2'($urandom_range(0, 3)); H_in0 = 4'($urandom_range(0, 15));
            M_in1 = 4'($urandom_range(0, 7)); M_in0 = 4'($urandom_range(0, 15));
            LD_time = 1'($urandom_range(0, 1)); LD_alarm = 1'($urandom_range(0, 1));
            AL_SEL = 2'($urandom); MODE_12H = 1'($urandom);
            step();
            LD_time = 1'b0; LD_alarm = 1'b0;
            repeat ($urandom_range(0, 3)) step();
        end
        MODE_12H = 1'b0;

        load_alarm(2, 10, 20);
        AL_EN = 4'b0100;
        load_time(10, 19);
        wait_alarm(1'b1, 130, n);
        chk("ring_lat", n, 122);
        chk("ring_id", Alarm_id, 2);
        wait_alarm(1'b0, 30, n);
        chk("ring_len", n, 10);

        AL_EN = 4'b0000;
        load_alarm(1, 7, 0);
        load_alarm(3, 7, 0);
        AL_EN = 4'b1010;
        load_time(6, 59);
        wait_alarm(1'b1, 130, n);
        chk("prio_id", Alarm_id, 1);
        STOP_al = 1'b1; SNOOZE = 1'b1; step(); STOP_al = 1'b0; SNOOZE = 1'b0;
        chk("stop_snz", Alarm, 0);
        count_high(130, n);
        chk("no_rering", n, 0);

        k = $urandom_range(0, 3); hh = $urandom_range(0, 23); mm = $urandom_range(1, 59);
        AL_EN = 4'b0000;
        load_alarm(k, hh, mm);
        AL_EN = 4'(1 << k);
        load_time(hh, mm - 1);
        wait_alarm(1'b1, 130, n);
        chk("snz_id0", Alarm_id, k);
        repeat ($urandom_range(0, 3)) step();
        SNOOZE = 1'b1; step(); SNOOZE = 1'b0;
        chk("snz_off", Alarm, 0);
        wait_alarm(1'b1, 130, n);
        chk("snz_60s", n >= 118 && n <= 122, 1);
        chk("snz_id1", Alarm_id, k);
        SNOOZE = 1'b1; step(); SNOOZE = 1'b0;
        repeat (5) step();
        STOP_al = 1'b1; step(); STOP_al = 1'b0;
        count_high(140, n);
        chk("snz_stop", n, 0);

        k = $urandom_range(0, 3); hh = $urandom_range(0, 23); mm = $urandom_range(1, 59);
        AL_EN = 4'b0000;
        load_alarm(k, hh, mm);
        AL_EN = 4'(1 << k);
        load_time(hh, mm - 1);
        wait_alarm(1'b1, 130, n);
        AL_EN = 4'b0000; step();
        chk("disarm", Alarm, 0);
        AL_EN = 4'(1 << k);
        repeat ($urandom_range(0, 3)) step();
        load_time(hh, mm);
        count_high(130, n);
        chk("direct_ld", n, 0);

        AL_EN = 4'b0000;
        MODE_12H = 1'b1;
        load_time(0, 30);
        chk("h12_0030", dtime(), 32'h123000);
        chk("pm_0030", PM, 0);
        load_time(13, 5);
        chk("h12_1305", dtime(), 32'h010500);
        chk("pm_1305", PM, 1);
        load_alarm(3, 13, 6);
        AL_EN = 4'b1000;
        wait_alarm(1'b1, 130, n);
        chk("pre_rst_id", Alarm_id, 3);
        reset = 1'b0; step(); reset = 1'b1;
        chk("rst_alarm", Alarm, 0);
        chk("rst_id", Alarm_id, 0);
        chk("rst_tick", tick, 0);
        chk("rst_time12", dtime(), 32'h120000);
        MODE_12H = 1'b0; #1;
        chk("rst_time24", dtime(), 32'h000000);
        chk("rst_pm", PM, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
